// File: rtl/cp0_pkg.sv
// cp0_pkg: shared definitions for the coprocessor-0 register block.
//   - CP0 register numbers (SR, Cause, EPC, PRId, Count, Compare)
//   - SR / Cause field bit positions and their packed storage structs
//   - exception-code width and the interrupt exception code
//   - helpers that expand stored fields into full 32-bit register images
package cp0_pkg;

  localparam int unsigned ExcSize = 5;
  localparam logic [ExcSize-1:0] ExcInt = 5'd0;

  localparam logic [4:0] RegCount   = 5'd9;
  localparam logic [4:0] RegCompare = 5'd11;
  localparam logic [4:0] RegSr      = 5'd12;
  localparam logic [4:0] RegCause   = 5'd13;
  localparam logic [4:0] RegEpc     = 5'd14;
  localparam logic [4:0] RegPrid    = 5'd15;

  localparam int unsigned SrImHi     = 15;
  localparam int unsigned SrImLo     = 10;
  localparam int unsigned SrExl      = 1;
  localparam int unsigned SrIe       = 0;
  localparam int unsigned CauseBd    = 31;
  localparam int unsigned CauseIpHi  = 15;
  localparam int unsigned CauseIpLo  = 10;
  localparam int unsigned CauseExcHi = 6;
  localparam int unsigned CauseExcLo = 2;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  typedef struct packed {
    logic               bd;
    logic [5:0]         ip;
    logic [ExcSize-1:0] exc;
  } cause_t;

  function automatic logic [31:0] pack_sr(sr_t s);
    logic [31:0] w;
    w                 = '0;
    w[SrImHi:SrImLo]  = s.im;
    w[SrExl]          = s.exl;
    w[SrIe]           = s.ie;
    return w;
  endfunction

  function automatic logic [31:0] pack_cause(cause_t c);
    logic [31:0] w;
    w                         = '0;
    w[CauseBd]                = c.bd;
    w[CauseIpHi:CauseIpLo]    = c.ip;
    w[CauseExcHi:CauseExcLo]  = c.exc;
    return w;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count / Compare timer, built only when CP0_TIMER_EN is defined.
// Ports:
//   clk, reset     pipeline clock, asynchronous active-high reset
//   wr_en_i        qualified mtc0 strobe (already gated by priority/protect)
//   wr_addr_i      mtc0 register number
//   din_i          mtc0 write data
//   rd_addr_i      mfc0 register number
//   rd_data_o      Count/Compare read data (0 for other numbers)
//   timer_irq_o    sticky Count==Compare pending flag
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en_i,
  input  logic [4:0]  wr_addr_i,
  input  logic [31:0] din_i,
  input  logic [4:0]  rd_addr_i,
  output logic [31:0] rd_data_o,
  output logic        timer_irq_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        pend_q, pend_d;

  logic wr_count, wr_compare;
  assign wr_count   = wr_en_i && (wr_addr_i == RegCount);
  assign wr_compare = wr_en_i && (wr_addr_i == RegCompare);

  always_comb begin
    count_d   = wr_count ? din_i : count_q + 32'd1;
    compare_d = wr_compare ? din_i : compare_q;
    // Writing Compare acknowledges the timer interrupt.
    pend_d    = wr_compare ? 1'b0 : (pend_q | (count_q == compare_q));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= 32'hFFFF_FFFF;
      pend_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    rd_data_o = '0;
    if (rd_addr_i == RegCount)   rd_data_o = count_q;
    if (rd_addr_i == RegCompare) rd_data_o = compare_q;
  end

  assign timer_irq_o = pend_q;

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: M-stage coprocessor-0 register block (SR, Cause, EPC, PRId).
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
// Ports:
//   clk, reset      pipeline clock, asynchronous active-high reset
//   PC              M-stage instruction address
//   A1 / DOut       mfc0 register number / combinational read data
//   A2 / Din        mtc0 register number / write data
//   CP0WE           mtc0 strobe, WriteProtect suppresses it
//   ExlSet / ExlClr exception taken / eret retiring
//   ExcCode, BD     cause code and delay-slot flag of the M-stage instruction
//   HWInt           level-sensitive external interrupt lines
//   IntReq          pending enabled interrupt (combinational from live HWInt)
//   EPC             current EPC register
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h4255_4141
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        PC,
  input  logic [4:0]         A1,
  input  logic [4:0]         A2,
  input  logic [31:0]        Din,
  input  logic               CP0WE,
  input  logic               WriteProtect,
  input  logic               ExlSet,
  input  logic               ExlClr,
  input  logic [ExcSize-1:0] ExcCode,
  input  logic               BD,
  input  logic [5:0]         HWInt,
  output logic               IntReq,
  output logic [31:0]        EPC,
  output logic [31:0]        DOut
);

  sr_t         sr_q, sr_d;
  cause_t      cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [5:0]  hw_int;
  logic        mtc0_en;

  // An exception taken this cycle drops any coincident mtc0 or eret.
  assign mtc0_en = CP0WE & ~WriteProtect & ~ExlSet;

`ifdef CP0_TIMER_EN
  logic        timer_irq;
  logic [31:0] timer_rdata;

  cp0_timer u_timer (
    .clk         (clk),
    .reset       (reset),
    .wr_en_i     (mtc0_en),
    .wr_addr_i   (A2),
    .din_i       (Din),
    .rd_addr_i   (A1),
    .rd_data_o   (timer_rdata),
    .timer_irq_o (timer_irq)
  );

  assign hw_int = {HWInt[5] | timer_irq, HWInt[4:0]};
`else
  assign hw_int = HWInt;
`endif

  always_comb begin
    sr_d     = sr_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    cause_d.ip = hw_int;
    if (ExlSet) begin
      sr_d.exl    = 1'b1;
      cause_d.exc = ExcCode;
      cause_d.bd  = BD;
      epc_d       = (BD ? PC - 32'd4 : PC) & ~32'd3;
    end else begin
      // mtc0 to SR owns EXL this cycle; otherwise eret clears it.
      if (mtc0_en && (A2 == RegSr)) begin
        sr_d.im  = Din[SrImHi:SrImLo];
        sr_d.exl = Din[SrExl];
        sr_d.ie  = Din[SrIe];
      end else if (ExlClr) begin
        sr_d.exl = 1'b0;
      end
      if (mtc0_en && (A2 == RegEpc)) begin
        epc_d = Din & ~32'd3;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q    <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      sr_q    <= sr_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    DOut = '0;
    case (A1)
      RegSr:    DOut = pack_sr(sr_q);
      RegCause: DOut = pack_cause(cause_q);
      RegEpc:   DOut = epc_q;
      RegPrid:  DOut = PRID;
`ifdef CP0_TIMER_EN
      RegCount, RegCompare: DOut = timer_rdata;
`endif
      default:  DOut = '0;
    endcase
  end

  assign IntReq = (|(hw_int & sr_q.im)) & sr_q.ie & ~sr_q.exl;
  assign EPC    = epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
module tb_cp0_unit;

  localparam logic [31:0] Prid   = 32'h4255_4141;
  localparam logic [31:0] SrMask = 32'h0000_FC03;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC, Din, EPC, DOut;
  logic [4:0]  A1, A2, ExcCode;
  logic        CP0WE, WriteProtect, ExlSet, ExlClr, BD, IntReq;
  logic [5:0]  HWInt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state kept as full architectural register words.
  logic [31:0] sr_m, cause_m, epc_m;
  logic [31:0] count_m, compare_m;
  logic        tpend_m;

  always #5 clk = ~clk;

  cp0_unit dut (
    .clk          (clk),
    .reset        (reset),
    .PC           (PC),
    .A1           (A1),
    .A2           (A2),
    .Din          (Din),
    .CP0WE        (CP0WE),
    .WriteProtect (WriteProtect),
    .ExlSet       (ExlSet),
    .ExlClr       (ExlClr),
    .ExcCode      (ExcCode),
    .BD           (BD),
    .HWInt        (HWInt),
    .IntReq       (IntReq),
    .EPC          (EPC),
    .DOut         (DOut)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    sr_m      = '0;
    cause_m   = '0;
    epc_m     = '0;
    count_m   = '0;
    compare_m = 32'hFFFF_FFFF;
    tpend_m   = 1'b0;
  endtask

  function automatic logic [5:0] eff_hwint();
`ifdef CP0_TIMER_EN
    return HWInt | {tpend_m, 5'b0};
`else
    return HWInt;
`endif
  endfunction

  function automatic logic exp_intreq();
    logic [5:0] pend;
    pend = eff_hwint() & sr_m[15:10];
    return (pend != 6'd0) && sr_m[0] && !sr_m[1];
  endfunction

  function automatic logic [31:0] exp_dout();
    case (A1)
      5'd12: return sr_m;
      5'd13: return cause_m;
      5'd14: return epc_m;
      5'd15: return Prid;
`ifdef CP0_TIMER_EN
      5'd9:  return count_m;
      5'd11: return compare_m;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Apply one rising edge worth of architectural rules to the model.
  task automatic model_edge();
    logic       wr;
    logic [5:0] hw;
    hw = eff_hwint();
    if (reset) begin
      model_reset();
      return;
    end
    wr = CP0WE && !WriteProtect && !ExlSet;
    if (ExlSet) begin
      sr_m    = sr_m | 32'h2;
      cause_m = (cause_m & ~32'h8000_007C) | ({31'd0, BD} << 31) | ({27'd0, ExcCode} << 2);
      epc_m   = (BD ? PC - 32'd4 : PC) & ~32'd3;
    end else begin
      if (wr && A2 == 5'd12) sr_m = Din & SrMask;
      else if (ExlClr)       sr_m = sr_m & ~32'h2;
      if (wr && A2 == 5'd14) epc_m = Din & ~32'd3;
    end
    cause_m = (cause_m & ~32'h0000_FC00) | ({26'd0, hw} << 10);
`ifdef CP0_TIMER_EN
    tpend_m = (wr && A2 == 5'd11) ? 1'b0 : (tpend_m || count_m == compare_m);
    if (wr && A2 == 5'd11) compare_m = Din;
    count_m = (wr && A2 == 5'd9) ? Din : count_m + 32'd1;
`endif
  endtask

  // Entered just after a falling edge with inputs already driven.
  task automatic tick();
    #1;
    check_eq("intreq", {31'd0, IntReq}, {31'd0, exp_intreq()});
    check_eq("epc", EPC, epc_m);
    check_eq("dout", DOut, exp_dout());
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    CP0WE = 0; WriteProtect = 0; ExlSet = 0; ExlClr = 0; BD = 0;
    ExcCode = '0; A2 = '0; Din = '0;
  endtask

  initial begin
    reset = 1'b1;
    PC = 32'h0000_3000; A1 = 5'd15; HWInt = '0;
    idle_inputs();
    model_reset();
    #2;
    check_eq("rst_prid", DOut, Prid);
    check_eq("rst_intreq", {31'd0, IntReq}, 32'd0);
    A1 = 5'd12;
    #1;
    check_eq("rst_sr", DOut, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Enable IM[10] and IE, then raise HWInt[0]: IntReq with zero latency.
    CP0WE = 1; A2 = 5'd12; Din = 32'h0000_0401;
    tick();
    idle_inputs(); HWInt = 6'b000001;
    #1 check_eq("intreq_on", {31'd0, IntReq}, 32'd1);
    tick();

    // Take the interrupt.
    ExlSet = 1; ExcCode = 5'd0; PC = 32'h0000_3010; BD = 0;
    tick();
    idle_inputs(); A1 = 5'd12;
    #1;
    check_eq("int_epc", EPC, 32'h0000_3010);
    check_eq("int_sr", DOut, 32'h0000_0403);
    check_eq("int_intreq", {31'd0, IntReq}, 32'd0);
    tick();

    // Exception in a delay slot.
    ExlSet = 1; ExcCode = 5'd10; PC = 32'h0000_3024; BD = 1;
    tick();
    idle_inputs(); A1 = 5'd13;
    #1;
    check_eq("bd_epc", EPC, 32'h0000_3020);
    check_eq("bd_cause_bd", {31'd0, DOut[31]}, 32'd1);
    check_eq("bd_cause_exc", {27'd0, DOut[6:2]}, 32'd10);
    tick();

    // ExlSet beats a coincident mtc0 and eret.
    ExlSet = 1; ExlClr = 1; CP0WE = 1; A2 = 5'd14; Din = 32'h0000_1234;
    PC = 32'h0000_4000; BD = 0; ExcCode = 5'd4;
    tick();
    idle_inputs(); A1 = 5'd12;
    #1;
    check_eq("prio_epc", EPC, 32'h0000_4000);
    check_eq("prio_exl", {31'd0, DOut[1]}, 32'd1);
    tick();
    CP0WE = 1; WriteProtect = 1; A2 = 5'd14; Din = 32'h0000_1234;
    tick();
    idle_inputs();
    #1 check_eq("wp_epc", EPC, 32'h0000_4000);
    tick();

    // eret with HWInt still high re-raises IntReq the next cycle.
    ExlClr = 1;
    #1 check_eq("eret_before", {31'd0, IntReq}, 32'd0);
    tick();
    idle_inputs();
    #1 check_eq("eret_after", {31'd0, IntReq}, 32'd1);
    tick();

    // PC-4 wraps.
    ExlSet = 1; BD = 1; PC = 32'h0000_0000;
    tick();
    idle_inputs();
    #1 check_eq("wrap_epc", EPC, 32'hFFFF_FFFC);
    tick();

`ifdef CP0_TIMER_EN
    CP0WE = 1; A2 = 5'd12; Din = 32'h0000_8001; HWInt = '0;
    tick();
    A2 = 5'd11; Din = 32'd20;
    tick();
    A2 = 5'd9; Din = 32'd0;
    tick();
    idle_inputs();
    repeat (21) tick();
    #1 check_eq("timer_irq", {31'd0, IntReq}, 32'd1);
    CP0WE = 1; A2 = 5'd11; Din = 32'd100;
    tick();
    idle_inputs();
    #1 check_eq("timer_clr", {31'd0, IntReq}, 32'd0);
    tick();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] regs [6];
      regs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
      A1 = ($urandom_range(0, 4) == 0) ? 5'($urandom) : regs[$urandom_range(0, 5)];
      A2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : regs[$urandom_range(0, 5)];
      Din          = $urandom;
      CP0WE        = ($urandom_range(0, 3) == 0);
      WriteProtect = ($urandom_range(0, 5) == 0);
      ExlSet       = ($urandom_range(0, 7) == 0);
      ExlClr       = ($urandom_range(0, 5) == 0);
      ExcCode      = 5'($urandom);
      BD           = 1'($urandom);
      PC           = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      HWInt        = 6'($urandom);
      tick();
    end

    // Asynchronous reset in the middle of an exception, strobe held across release.
    ExlSet = 1; BD = 0; PC = 32'h0000_5008; ExcCode = 5'd12; A1 = 5'd14;
    #2 reset = 1'b1;
    #1;
    check_eq("arst_epc", EPC, 32'd0);
    check_eq("arst_dout", DOut, 32'd0);
    check_eq("arst_intreq", {31'd0, IntReq}, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    #1 check_eq("post_rst_epc", EPC, 32'h0000_5008);
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 register block for the pipelined MIPS core. Holds SR, Cause, EPC and PRId. Sits in the M stage: it samples hardware interrupt lines and the exception code and branch-delay flag gathered through the pipeline, and drives the interrupt request consumed by the exception controller. It also receives the controller's EXL-set/clear and CP0-write strobes, and supplies EPC to the PC-select path and mfc0 read data to the W-stage mux.

## Interface
Parameters:
- PRID, 32'h4255_4141, read-only processor ID returned for register 15.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- PC  in  32  M-stage instruction address (word aligned).
- A1  in  5  mfc0 read register number (EM_IR rd).
- A2  in  5  mtc0 write register number (EM_IR rd).
- Din  in  32  mtc0 write data (forwarded rt value).
- CP0WE  in  1  mtc0 write strobe (M_CP0WE).
- WriteProtect  in  1  suppresses CP0WE this cycle (exception in flight).
- ExlSet  in  1  exception/interrupt taken this cycle.
- ExlClr  in  1  eret retiring in M (M_ExlClr).
- ExcCode  in  5  cause code of the M-stage instruction; 0 means interrupt.
- BD  in  1  M-stage instruction is in a branch delay slot.
- HWInt  in  6  external interrupt lines, level sensitive, synchronous to clk.
- IntReq  out  1  pending enabled interrupt.
- EPC  out  32  current EPC register, for eret redirect.
- DOut  out  32  contents of register A1.

## Operation
- SR (12): only IM[15:10], EXL[1] and IE[0] are stored; all other bits read as 0.
- Cause (13): BD[31], IP[15:10] and ExcCode[6:2] are stored; all other bits read as 0. Cause is read-only to mtc0; writes are ignored.
- EPC (14): 32-bit, read/write.
- PRId (15): constant PRID.
- Any other register number reads 0 and ignores writes.
- IP[15:10] is loaded from HWInt every cycle, unconditionally.
- IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL. It is combinational from live HWInt and registered SR.
- On an ExlSet edge:
  - SR.EXL <= 1.
  - Cause.ExcCode <= ExcCode.
  - Cause.BD <= BD.
  - EPC <= BD ? PC-4 : PC, with bits [1:0] forced to 0.
- On an ExlClr edge: SR.EXL <= 0. Nothing else changes.
- On a mtc0 edge (CP0WE & ~WriteProtect):
  - A2=12 writes the SR fields.
  - A2=14 writes EPC, with bits [1:0] forced to 0.
- Priority when strobes coincide: ExlSet > mtc0 > ExlClr. If ExlSet is asserted, any mtc0 or eret in the same cycle is dropped entirely.
- PC-4 wraps modulo 2^32.

## Timing
- Reset values: SR=0, Cause=0, EPC=0, IntReq=0. DOut is 0 unless A1=15, in which case it is PRID.
- DOut and EPC are combinational reads of registered state. There is no write-to-read bypass: a mtc0 is visible to a read one cycle later.
- The ExlSet update is visible on the cycle after the edge. IntReq therefore deasserts the cycle after the interrupt is taken.
- HWInt reaches IntReq with zero latency. It reaches Cause.IP with one cycle of latency.
- A reset asserted in the middle of an exception returns all state to reset values asynchronously. A strobe held across reset release takes effect on the first edge after release.

## Configuration
- CP0_TIMER_EN, when defined:
  - Adds Count (9) and Compare (11) registers, both 32-bit and read/write via mtc0/mfc0.
  - Count increments every cycle and wraps. An mtc0 to Count loads Din instead of incrementing that cycle.
  - When Count==Compare, a sticky timer-pending flag sets. An mtc0 to Compare clears the flag.
  - The flag is ORed into HWInt[5] before both IP sampling and the IntReq calculation.
  - Reset: Count=0, Compare=32'hFFFF_FFFF, flag=0.
- When CP0_TIMER_EN is undefined:
  - Registers 9 and 11 read 0 and ignore writes.
  - HWInt is used unmodified.

## Structure
- The shared header holds:
  - CP0 register numbers (SR, CAUSE, EPC, PRID, COUNT, COMPARE).
  - SR/Cause field bit positions.
  - exc_size (5) and the interrupt ExcCode value (0).
- The timer is a natural sub-module, cp0_timer, present only under CP0_TIMER_EN. It outputs timer_irq and its register read data.

## Test plan
- Reset with A1=15 → DOut=32'h4255_4141; A1=12 → DOut=0; IntReq=0.
- mtc0 SR=32'h0000_0401, then HWInt=6'b000001 → IntReq=1 in the same cycle. Pulse ExlSet with ExcCode=0, PC=32'h0000_3010, BD=0 → next cycle EPC=32'h0000_3010, SR reads 32'h0000_0403, IntReq=0.
- ExlSet with BD=1, PC=32'h0000_3024, ExcCode=10 → EPC=32'h0000_3020, Cause[31]=1, Cause[6:2]=10.
- ExlSet, CP0WE (A2=14, Din=32'h1234) and ExlClr in the same cycle → EPC takes the exception value, EXL=1, and the write is lost. Repeat with WriteProtect=1 and no ExlSet → EPC unchanged.
- ExlClr with EXL=1, IM/IE set and HWInt still high → the cycle after the edge IntReq=1.
- Under CP0_TIMER_EN: with SR=32'h0000_8001, write Compare=20 and Count=0 → timer flag and IntReq assert after 20 increments. Writing Compare=100 clears both.
